// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline back end: widths, the register-0 index,
// the memory-handshake state encoding and the register-write qualifier.
package pipe_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } mem_state_e;

    // Register 0 is hardwired, so a write to it never counts as a write.
    function automatic logic writes_reg(input logic             valid,
                                        input logic             reg_wr,
                                        input logic [REG_W-1:0] dest);
        return valid & reg_wr & (dest != REG_ZERO);
    endfunction

endpackage

// File: rtl/mem_handshake.sv
// Memory req/ack sequencer: access FSM, timeout counter, pipeline stall and
// the sticky bus-error flag.
module mem_handshake
    import pipe_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ex_mem_op,
    input  logic ex_we,
    input  logic m_we,
    input  logic mem_ack,
    output logic mem_req,
    output logic mem_we,
    output logic stall,
    output logic bus_err,
    output logic acc_done,
    output logic abort
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mem_state_e       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             pend_r;
    logic             req_r;
    logic             we_r;
    logic             bus_err_r;

    logic in_access_s;
    logic timeout_s;
    logic acc_done_s;
    logic abort_s;
    logic stall_s;

    // Decode completion, timeout and stall from the current state.
    always_comb begin
        in_access_s = (state_r == ST_ACCESS);
        timeout_s   = in_access_s & (cnt_r == CNT_LAST);
        acc_done_s  = in_access_s & mem_ack;
        abort_s     = timeout_s & ~mem_ack;
        // A memory op captured on the completion edge of the previous one
        // waits one idle cycle (pend_r) so that mem_req visibly drops.
        if (in_access_s) begin
            stall_s = ~mem_ack & ~timeout_s;
        end else begin
            stall_s = pend_r;
        end
    end

    // Access FSM with timeout counter and registered request strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            pend_r    <= 1'b0;
            req_r     <= 1'b0;
            we_r      <= 1'b0;
            bus_err_r <= 1'b0;
        end else begin
            if (abort_s) begin
                bus_err_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (pend_r | ex_mem_op) begin
                        state_r <= ST_ACCESS;
                        cnt_r   <= {CNT_W{1'b0}};
                        req_r   <= 1'b1;
                        we_r    <= pend_r ? m_we : ex_we;
                        pend_r  <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    if (acc_done_s | timeout_s) begin
                        state_r <= ST_IDLE;
                        req_r   <= 1'b0;
                        we_r    <= 1'b0;
                        pend_r  <= ex_mem_op;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= {CNT_W{1'b0}};
                    pend_r  <= 1'b0;
                    req_r   <= 1'b0;
                    we_r    <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req  = req_r;
    assign mem_we   = we_r;
    assign stall    = stall_s;
    assign bus_err  = bus_err_r;
    assign acc_done = acc_done_s;
    assign abort    = abort_s;

endmodule

// File: rtl/mem_wb_stage.sv
// Memory / write-back back end: M and WB pipeline registers, load-data mux,
// forward tap and register-file write port.
module mem_wb_stage
    import pipe_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [REG_W-1:0]  ex_dest,
    input  logic              ex_reg_wr,
    input  logic              ex_mem_rd,
    input  logic              ex_mem_wr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall,
    output logic              REG_WR,
    output logic [REG_W-1:0]  DIR_WR,
    output logic [DATA_W-1:0] DI,
    output logic              m_fwd_valid,
    output logic [REG_W-1:0]  m_fwd_dest,
    output logic [DATA_W-1:0] m_fwd_data,
    output logic              bus_err
);

    logic              m_valid_r;
    logic [DATA_W-1:0] m_result_r;
    logic [DATA_W-1:0] m_store_data_r;
    logic [REG_W-1:0]  m_dest_r;
    logic              m_reg_wr_r;
    logic              m_mem_rd_r;
    logic              m_mem_wr_r;
    logic              m_fwd_valid_r;

    logic              reg_wr_r;
    logic [REG_W-1:0]  dir_wr_r;
    logic [DATA_W-1:0] di_r;

    logic stall_s;
    logic acc_done_s;
    logic abort_s;
    logic ex_mem_op_s;
    logic ex_we_s;
    logic m_we_s;

    // A simultaneous read and write request is treated as a read.
    assign ex_mem_op_s = ex_valid & (ex_mem_rd | ex_mem_wr);
    assign ex_we_s     = ex_mem_wr & ~ex_mem_rd;
    assign m_we_s      = m_mem_wr_r & ~m_mem_rd_r;

    mem_handshake #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_mem_handshake (
        .clk      (clk),
        .rst_n    (rst_n),
        .ex_mem_op(ex_mem_op_s),
        .ex_we    (ex_we_s),
        .m_we     (m_we_s),
        .mem_ack  (mem_ack),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .stall    (stall_s),
        .bus_err  (bus_err),
        .acc_done (acc_done_s),
        .abort    (abort_s)
    );

    // M register: captures the execute stage whenever the pipeline advances.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid_r      <= 1'b0;
            m_result_r     <= {DATA_W{1'b0}};
            m_store_data_r <= {DATA_W{1'b0}};
            m_dest_r       <= REG_ZERO;
            m_reg_wr_r     <= 1'b0;
            m_mem_rd_r     <= 1'b0;
            m_mem_wr_r     <= 1'b0;
            m_fwd_valid_r  <= 1'b0;
        end else if (!stall_s) begin
            m_valid_r      <= ex_valid;
            m_result_r     <= ex_result;
            m_store_data_r <= ex_store_data;
            m_dest_r       <= ex_dest;
            m_reg_wr_r     <= ex_reg_wr;
            m_mem_rd_r     <= ex_mem_rd;
            m_mem_wr_r     <= ex_mem_wr;
            // Load results are not known yet, so loads never forward from M.
            m_fwd_valid_r  <= writes_reg(ex_valid, ex_reg_wr & ~ex_mem_rd, ex_dest);
        end
    end

    // WB register: bubble while stalled, aborted accesses retire silently.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reg_wr_r <= 1'b0;
            dir_wr_r <= REG_ZERO;
            di_r     <= {DATA_W{1'b0}};
        end else if (!stall_s) begin
            reg_wr_r <= writes_reg(m_valid_r & ~abort_s, m_reg_wr_r, m_dest_r);
            dir_wr_r <= m_dest_r;
            di_r     <= (acc_done_s & m_mem_rd_r) ? mem_rdata : m_result_r;
        end else begin
            reg_wr_r <= 1'b0;
        end
    end

    assign stall       = stall_s;
    assign mem_addr    = m_result_r;
    assign mem_wdata   = m_store_data_r;
    assign m_fwd_valid = m_fwd_valid_r;
    assign m_fwd_dest  = m_dest_r;
    assign m_fwd_data  = m_result_r;
    assign REG_WR      = reg_wr_r;
    assign DIR_WR      = dir_wr_r;
    assign DI          = di_r;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: ALU vector table plus hand-written
// sequences for loads, stores, timeout, back-to-back access and reset.
module tb_mem_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic [31:0] ex_result;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_dest;
    logic        ex_reg_wr;
    logic        ex_mem_rd;
    logic        ex_mem_wr;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall;
    logic        REG_WR;
    logic [4:0]  DIR_WR;
    logic [31:0] DI;
    logic        m_fwd_valid;
    logic [4:0]  m_fwd_dest;
    logic [31:0] m_fwd_data;
    logic        bus_err;

    int checks   = 0;
    int failures = 0;

    mem_wb_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid     (ex_valid),
        .ex_result    (ex_result),
        .ex_store_data(ex_store_data),
        .ex_dest      (ex_dest),
        .ex_reg_wr    (ex_reg_wr),
        .ex_mem_rd    (ex_mem_rd),
        .ex_mem_wr    (ex_mem_wr),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .stall        (stall),
        .REG_WR       (REG_WR),
        .DIR_WR       (DIR_WR),
        .DI           (DI),
        .m_fwd_valid  (m_fwd_valid),
        .m_fwd_dest   (m_fwd_dest),
        .m_fwd_data   (m_fwd_data),
        .bus_err      (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  dest;
        logic        reg_wr;
        logic        exp_fwd;
        logic        exp_wr;
    } alu_vec_t;

    alu_vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic v, input logic [31:0] res, input logic [31:0] sd,
                            input logic [4:0] d, input logic rw, input logic rd, input logic wr);
        ex_valid      = v;
        ex_result     = res;
        ex_store_data = sd;
        ex_dest       = d;
        ex_reg_wr     = rw;
        ex_mem_rd     = rd;
        ex_mem_wr     = wr;
    endtask

    task automatic idle_ex();
        drive_ex(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Hard stop in case a sequence ever loses track of the DUT.
    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        int req_cnt;
        int stall_cnt;
        int wr_seen;

        vecs[0] = '{32'h0000_1234, 5'd5,  1'b1, 1'b1, 1'b1};
        vecs[1] = '{32'hFFFF_FFFF, 5'd31, 1'b1, 1'b1, 1'b1};
        vecs[2] = '{32'h0000_0055, 5'd0,  1'b1, 1'b0, 1'b0};
        vecs[3] = '{32'h0000_0077, 5'd7,  1'b0, 1'b0, 1'b0};

        rst_n     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        idle_ex();
        tick();
        tick();
        check("rst_reg_wr",  32'(REG_WR), 32'd0);
        check("rst_dir_wr",  32'(DIR_WR), 32'd0);
        check("rst_di",      DI,          32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we",  32'(mem_we),  32'd0);
        check("rst_addr",    mem_addr,    32'd0);
        check("rst_wdata",   mem_wdata,   32'd0);
        check("rst_stall",   32'(stall),  32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        check("rst_fwd",     32'(m_fwd_valid), 32'd0);
        rst_n = 1'b1;
        tick();

        // ALU ops from the vector table.
        for (int i = 0; i < 4; i++) begin
            drive_ex(1'b1, vecs[i].result, 32'h0, vecs[i].dest, vecs[i].reg_wr, 1'b0, 1'b0);
            tick();
            idle_ex();
            check("alu_fwd_valid", 32'(m_fwd_valid), 32'(vecs[i].exp_fwd));
            check("alu_fwd_dest",  32'(m_fwd_dest),  32'(vecs[i].dest));
            check("alu_fwd_data",  m_fwd_data,       vecs[i].result);
            check("alu_stall",     32'(stall),       32'd0);
            check("alu_wr_early",  32'(REG_WR),      32'd0);
            tick();
            check("alu_reg_wr", 32'(REG_WR), 32'(vecs[i].exp_wr));
            check("alu_dir_wr", 32'(DIR_WR), 32'(vecs[i].dest));
            check("alu_di",     DI,          vecs[i].result);
            tick();
            check("alu_wr_once", 32'(REG_WR), 32'd0);
        end

        // Load with ack in the third access cycle.
        drive_ex(1'b1, 32'h0000_0040, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0);
        tick();
        idle_ex();
        check("ld_addr",      mem_addr,          32'h0000_0040);
        check("ld_we",        32'(mem_we),       32'd0);
        check("ld_fwd_valid", 32'(m_fwd_valid),  32'd0);
        req_cnt   = 0;
        stall_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'hDEAD_BEEF;
            end
            #1;
            req_cnt   = req_cnt + int'(mem_req);
            stall_cnt = stall_cnt + int'(stall);
            tick();
            mem_ack   = 1'b0;
            mem_rdata = 32'h0;
        end
        check("ld_req_cycles",   32'(req_cnt),   32'd3);
        check("ld_stall_cycles", 32'(stall_cnt), 32'd2);
        check("ld_reg_wr",       32'(REG_WR),    32'd1);
        check("ld_di",           DI,             32'hDEAD_BEEF);
        check("ld_dir_wr",       32'(DIR_WR),    32'd9);
        check("ld_req_drop",     32'(mem_req),   32'd0);
        tick();

        // Store, acked in its second access cycle.
        drive_ex(1'b1, 32'h0000_0080, 32'hA5A5_A5A5, 5'd3, 1'b0, 1'b0, 1'b1);
        tick();
        idle_ex();
        wr_seen = 0;
        for (int c = 0; c < 2; c++) begin
            check("st_req",   32'(mem_req), 32'd1);
            check("st_we",    32'(mem_we),  32'd1);
            check("st_addr",  mem_addr,     32'h0000_0080);
            check("st_wdata", mem_wdata,    32'hA5A5_A5A5);
            if (c == 1) mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
            wr_seen = wr_seen + int'(REG_WR);
        end
        tick();
        wr_seen = wr_seen + int'(REG_WR);
        check("st_no_reg_wr", 32'(wr_seen), 32'd0);
        check("st_req_drop",  32'(mem_req), 32'd0);

        // Ack while idle must be ignored.
        mem_ack   = 1'b1;
        mem_rdata = 32'h1357_9BDF;
        tick();
        mem_ack = 1'b0;
        tick();
        check("stray_ack_wr",  32'(REG_WR),  32'd0);
        check("stray_ack_req", 32'(mem_req), 32'd0);

        // Ack exactly on the timeout cycle: the ack wins.
        drive_ex(1'b1, 32'h0000_0200, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0);
        tick();
        idle_ex();
        tick();
        tick();
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        #1;
        check("tack_stall", 32'(stall), 32'd0);
        tick();
        mem_ack = 1'b0;
        check("tack_reg_wr",  32'(REG_WR),  32'd1);
        check("tack_di",      DI,           32'hCAFE_F00D);
        check("tack_bus_err", 32'(bus_err), 32'd0);
        tick();

        // Back-to-back loads: one-cycle gap in mem_req between them.
        drive_ex(1'b1, 32'h0000_0300, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0);
        tick();
        drive_ex(1'b1, 32'h0000_0304, 32'h0, 5'd12, 1'b1, 1'b1, 1'b0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1111_1111;
        #1;
        check("b2b_first_stall", 32'(stall), 32'd0);
        tick();
        idle_ex();
        mem_ack = 1'b0;
        check("b2b_a_reg_wr", 32'(REG_WR),  32'd1);
        check("b2b_a_di",     DI,           32'h1111_1111);
        check("b2b_a_dest",   32'(DIR_WR),  32'd11);
        check("b2b_gap_req",  32'(mem_req), 32'd0);
        tick();
        check("b2b_b_req",  32'(mem_req), 32'd1);
        check("b2b_b_addr", mem_addr,     32'h0000_0304);
        check("b2b_bubble", 32'(REG_WR),  32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h2222_2222;
        tick();
        mem_ack = 1'b0;
        check("b2b_b_reg_wr", 32'(REG_WR), 32'd1);
        check("b2b_b_di",     DI,          32'h2222_2222);
        check("b2b_b_dest",   32'(DIR_WR), 32'd12);
        tick();

        // Timeout: no ack at all.
        drive_ex(1'b1, 32'h0000_0100, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0);
        tick();
        idle_ex();
        req_cnt   = 0;
        stall_cnt = 0;
        wr_seen   = 0;
        for (int c = 0; c < 8; c++) begin
            req_cnt   = req_cnt + int'(mem_req);
            stall_cnt = stall_cnt + int'(stall);
            wr_seen   = wr_seen + int'(REG_WR);
            tick();
        end
        check("to_req_cycles",   32'(req_cnt),   32'd4);
        check("to_stall_cycles", 32'(stall_cnt), 32'd3);
        check("to_no_reg_wr",    32'(wr_seen),   32'd0);
        check("to_bus_err",      32'(bus_err),   32'd1);
        drive_ex(1'b1, 32'h0000_0099, 32'h0, 5'd6, 1'b1, 1'b0, 1'b0);
        tick();
        idle_ex();
        tick();
        check("to_next_reg_wr",  32'(REG_WR),  32'd1);
        check("to_next_di",      DI,           32'h0000_0099);
        check("to_next_dir",     32'(DIR_WR),  32'd6);
        check("to_bus_err_hold", 32'(bus_err), 32'd1);
        tick();

        // Reset in the middle of an access; a late ack does nothing.
        drive_ex(1'b1, 32'h0000_0400, 32'h0, 5'd13, 1'b1, 1'b1, 1'b0);
        tick();
        idle_ex();
        check("mrst_req_before", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mrst_req",     32'(mem_req),     32'd0);
        check("mrst_stall",   32'(stall),       32'd0);
        check("mrst_bus_err", 32'(bus_err),     32'd0);
        check("mrst_reg_wr",  32'(REG_WR),      32'd0);
        check("mrst_addr",    mem_addr,         32'd0);
        check("mrst_fwd",     32'(m_fwd_valid), 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0BAD_0BAD;
        tick();
        mem_ack = 1'b0;
        wr_seen = int'(REG_WR);
        tick();
        wr_seen = wr_seen + int'(REG_WR);
        check("mrst_late_ack_wr", 32'(wr_seen), 32'd0);
        check("mrst_late_req",    32'(mem_req), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
